// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and helpers for the instruction/data RAM arbiter.
//   - state_e      : arbiter FSM states (IDLE, RMW_WR)
//   - SIZE_B/H/W   : D_SIZE encodings (byte, halfword, word; 2'b11 is illegal)
//   - merge_store  : lays right-aligned store data into the addressed lanes
//                    of the old RAM word
//   - misaligned   : flags accesses whose size does not fit at the byte offset
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      RMW_WR = 1'b1
   } state_e;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   function automatic logic [DATA_W-1:0] merge_store(
      input logic [DATA_W-1:0] old_word,
      input logic [DATA_W-1:0] wdata,
      input logic [1:0]        size,
      input logic [1:0]        off
   );
      logic [DATA_W-1:0] m;
      m = old_word;
      case (size)
         SIZE_B: begin
            case (off)
               2'd0:    m[7:0]   = wdata[7:0];
               2'd1:    m[15:8]  = wdata[7:0];
               2'd2:    m[23:16] = wdata[7:0];
               default: m[31:24] = wdata[7:0];
            endcase
         end
         SIZE_H: begin
            if (off[1]) m[31:16] = wdata[15:0];
            else        m[15:0]  = wdata[15:0];
         end
         default: m = wdata;
      endcase
      return m;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SIZE_B:  return 1'b0;
         SIZE_H:  return off[0];
         SIZE_W:  return (off != 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/store_merge.sv
// -----------------------------------------------------------------------------
// store_merge
//   Combinational lane merge for sub-word stores plus misalignment detect.
//   Ports:
//     i_old      old RAM word read back for the merge
//     i_wdata    right-aligned store data
//     i_size     access size (SIZE_B/SIZE_H/SIZE_W, 2'b11 illegal)
//     i_off      byte offset within the word (address bits [1:0])
//     o_merged   old word with the addressed lanes replaced
//     o_misalign access does not fit at this offset (or illegal size)
// -----------------------------------------------------------------------------
module store_merge
   import mem_arb_pkg::*;
(
   input  logic [DATA_W-1:0] i_old,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [1:0]        i_size,
   input  logic [1:0]        i_off,
   output logic [DATA_W-1:0] o_merged,
   output logic              o_misalign
);

   assign o_merged   = merge_store(i_old, i_wdata, i_size, i_off);
   assign o_misalign = misaligned(i_size, i_off);

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, word-addressed RAM (async read, sync write)
//   between instruction fetch (I) and the load/store unit (D). Arbitrates
//   per cycle, registers read data, and turns byte/half stores into a
//   two-cycle read-modify-write since the RAM has no byte enables.
//   Ports:
//     CLK, RST_N                 clock, synchronous active-low reset
//     I_REQ/I_ADDR               fetch request and byte address
//     I_GNT                      fetch accepted this cycle (combinational)
//     I_RVALID/I_RDATA           fetched word, one cycle after I_GNT
//     D_REQ/D_WE/D_SIZE/D_ADDR/D_WDATA   data request
//     D_GNT                      data accepted this cycle (combinational)
//     D_RVALID/D_RDATA/D_ERR     load data / store done / misalign pulse
//     RAM_WE/RAM_A/RAM_WD        to RAM (RAM_A always word-aligned)
//     RAM_RD                     from RAM, combinational read
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic            I_REQ,
   input  logic [WORD-1:0] I_ADDR,
   output logic            I_GNT,
   output logic            I_RVALID,
   output logic [WORD-1:0] I_RDATA,
   input  logic            D_REQ,
   input  logic            D_WE,
   input  logic [1:0]      D_SIZE,
   input  logic [WORD-1:0] D_ADDR,
   input  logic [WORD-1:0] D_WDATA,
   output logic            D_GNT,
   output logic            D_RVALID,
   output logic [WORD-1:0] D_RDATA,
   output logic            D_ERR,
   output logic            RAM_WE,
   output logic [WORD-1:0] RAM_A,
   output logic [WORD-1:0] RAM_WD,
   input  logic [WORD-1:0] RAM_RD
);

   localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [WORD-1:0]  ALIGN_MSK  = ~WORD'(3);

   state_e           r_state;
   logic [CNT_W-1:0] r_starve_cnt;
   logic [WORD-1:0]  r_merge;
   logic [WORD-1:0]  r_rmw_addr;

   logic             w_idle;
   logic             w_d_win;
   logic             w_i_win;
   logic             w_misalign;
   logic             w_word_store;
   logic [WORD-1:0]  w_merged;
   logic [WORD-1:0]  w_sel_addr;

   // Merge is computed from the live RAM read in the grant cycle and parked
   // in r_merge, so the write cycle never sees RAM_RD combinationally.
   store_merge u_store_merge (
      .i_old      (RAM_RD),
      .i_wdata    (D_WDATA),
      .i_size     (D_SIZE),
      .i_off      (D_ADDR[1:0]),
      .o_merged   (w_merged),
      .o_misalign (w_misalign)
   );

   // D has priority until I has been refused STARVE_MAX times in a row.
   assign w_idle       = (r_state == IDLE);
   assign w_d_win      = w_idle && D_REQ && (r_starve_cnt < STARVE_LIM);
   assign w_i_win      = w_idle && !w_d_win && I_REQ;
   assign D_GNT        = w_d_win;
   assign I_GNT        = w_i_win;
   assign w_sel_addr   = w_d_win ? D_ADDR : I_ADDR;
   assign w_word_store = w_d_win && D_WE && !w_misalign && (D_SIZE == SIZE_W);

   always_comb begin
      // NOTE: every output gets a default before any condition, so no latch
      // is inferred.
      RAM_A  = w_sel_addr & ALIGN_MSK;
      RAM_WD = D_WDATA;
      RAM_WE = w_word_store;
      if (r_state == RMW_WR) begin
         RAM_A  = r_rmw_addr;
         RAM_WD = r_merge;
         RAM_WE = 1'b1;
      end
      // Reset is synchronous, so the FSM may still sit in RMW_WR while RST_N
      // is low; the write must be suppressed combinationally.
      if (!RST_N) RAM_WE = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side reads the pre-edge value.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_merge      <= '0;
         r_rmw_addr   <= '0;
         I_RVALID     <= 1'b0;
         I_RDATA      <= '0;
         D_RVALID     <= 1'b0;
         D_RDATA      <= '0;
         D_ERR        <= 1'b0;
      end else begin
         I_RVALID <= w_i_win;
         D_RVALID <= 1'b0;
         D_ERR    <= 1'b0;

         if (w_i_win) I_RDATA <= RAM_RD;

         if (I_REQ && !w_i_win) begin
            if (r_starve_cnt != STARVE_LIM) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
         end else begin
            r_starve_cnt <= '0;
         end

         case (r_state)
            IDLE: begin
               if (w_d_win) begin
                  if (w_misalign) begin
                     D_RVALID <= 1'b1;
                     D_ERR    <= 1'b1;
                  end else if (!D_WE) begin
                     D_RVALID <= 1'b1;
                     D_RDATA  <= RAM_RD;
                  end else if (D_SIZE == SIZE_W) begin
                     D_RVALID <= 1'b1;
                  end else begin
                     r_merge    <= w_merged;
                     r_rmw_addr <= D_ADDR & ALIGN_MSK;
                     r_state    <= RMW_WR;
                  end
               end
            end
            RMW_WR: begin
               D_RVALID <= 1'b1;
               r_state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural RAM. Expected read
//   responses are queued when a request is granted; a negedge monitor pops
//   and compares whenever I_RVALID or D_RVALID is seen.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        CLK, RST_N;
   logic        I_REQ, I_GNT, I_RVALID;
   logic [31:0] I_ADDR, I_RDATA;
   logic        D_REQ, D_WE, D_GNT, D_RVALID, D_ERR;
   logic [1:0]  D_SIZE;
   logic [31:0] D_ADDR, D_WDATA, D_RDATA;
   logic        RAM_WE;
   logic [31:0] RAM_A, RAM_WD, RAM_RD;

   mem_arbiter #(.WORD(32), .STARVE_MAX(4)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
      .D_REQ(D_REQ), .D_WE(D_WE), .D_SIZE(D_SIZE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
      .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
      .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_WD(RAM_WD), .RAM_RD(RAM_RD)
   );

   // Behavioural RAM: 64 words, async read, sync write.
   logic [31:0] mem [0:63];
   assign RAM_RD = mem[RAM_A[7:2]];
   always @(posedge CLK) if (RAM_WE) mem[RAM_A[7:2]] <= RAM_WD;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_vec  = 0;
   int n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard
   typedef struct packed {
      logic        err;
      logic        chk;
      logic [31:0] data;
   } d_exp_t;

   logic [31:0] i_q [$];
   d_exp_t      d_q [$];
   logic [31:0] i_e;
   d_exp_t      d_e;
   logic [31:0] last_d;   // expected D_RDATA holding value

   always @(negedge CLK) begin
      if (I_RVALID) begin
         if (i_q.size() == 0) check("i_rvalid_unexpected", {31'd0, I_RVALID}, 32'd0);
         else begin
            i_e = i_q.pop_front();
            check("i_rdata", I_RDATA, i_e);
         end
      end
      if (D_RVALID) begin
         if (d_q.size() == 0) check("d_rvalid_unexpected", {31'd0, D_RVALID}, 32'd0);
         else begin
            d_e = d_q.pop_front();
            check("d_err", {31'd0, D_ERR}, {31'd0, d_e.err});
            if (d_e.chk) check("d_rdata", D_RDATA, d_e.data);
         end
      end else if (D_ERR) begin
         check("d_err_without_rvalid", {31'd0, D_ERR}, 32'd0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      I_REQ = 1'b0; I_ADDR = 32'h0;
      D_REQ = 1'b0; D_WE = 1'b0; D_SIZE = SIZE_W; D_ADDR = 32'h0; D_WDATA = 32'h0;
   endtask

   task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
      I_REQ = 1'b1; I_ADDR = addr;
      #1;
      check("fetch_gnt", {31'd0, I_GNT}, 32'd1);
      check("fetch_ram_a", RAM_A, addr & 32'hFFFF_FFFC);
      i_q.push_back(exp);
      tick();
      I_REQ = 1'b0;
      check("fetch_rvalid_lat", {31'd0, I_RVALID}, 32'd1);
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] exp);
      D_REQ = 1'b1; D_WE = 1'b0; D_SIZE = SIZE_W; D_ADDR = addr;
      #1;
      check("load_gnt", {31'd0, D_GNT}, 32'd1);
      d_q.push_back('{err: 1'b0, chk: 1'b1, data: exp});
      last_d = exp;
      tick();
      idle_inputs();
      check("load_rvalid_lat", {31'd0, D_RVALID}, 32'd1);
   endtask

   task automatic rmw(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata,
                      input int idx, input logic [31:0] exp);
      D_REQ = 1'b1; D_WE = 1'b1; D_SIZE = size; D_ADDR = addr; D_WDATA = wdata;
      #1;
      check("rmw_gnt", {31'd0, D_GNT}, 32'd1);
      check("rmw_read_we", {31'd0, RAM_WE}, 32'd0);
      d_q.push_back('{err: 1'b0, chk: 1'b0, data: 32'h0});
      tick();
      idle_inputs();
      I_REQ = 1'b1; I_ADDR = 32'h10;
      #1;
      check("rmw_write_we", {31'd0, RAM_WE}, 32'd1);
      check("rmw_write_a", RAM_A, addr & 32'hFFFF_FFFC);
      check("rmw_write_wd", RAM_WD, exp);
      check("rmw_i_blocked", {31'd0, I_GNT}, 32'd0);
      check("rmw_rvalid_early", {31'd0, D_RVALID}, 32'd0);
      tick();
      check("rmw_rvalid_lat", {31'd0, D_RVALID}, 32'd1);
      check("rmw_mem", mem[idx], exp);
      check("rmw_i_after", {31'd0, I_GNT}, 32'd1);
      i_q.push_back(32'hDEAD_BEEF);
      tick();
      I_REQ = 1'b0;
   endtask

   task automatic misalign(input logic [31:0] addr, input logic [1:0] size, input logic we);
      D_REQ = 1'b1; D_WE = we; D_SIZE = size; D_ADDR = addr; D_WDATA = 32'hFFFF_FFFF;
      #1;
      check("mis_gnt", {31'd0, D_GNT}, 32'd1);
      check("mis_we_t", {31'd0, RAM_WE}, 32'd0);
      d_q.push_back('{err: 1'b1, chk: 1'b1, data: last_d});
      tick();
      idle_inputs();
      #1;
      check("mis_we_t1", {31'd0, RAM_WE}, 32'd0);
      check("mis_err_lat", {31'd0, D_ERR}, 32'd1);
   endtask

   // Sub-word store vectors: address, size, data, word index, merged result.
   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      int          idx;
      logic [31:0] exp;
   } rmw_vec_t;

   rmw_vec_t rmw_tab [5];

   logic [9:0] i_win_pat;

   initial begin
      rmw_tab[0] = '{32'h21, SIZE_B, 32'h5555_55AA, 8,  32'h1122_AA44};
      rmw_tab[1] = '{32'h22, SIZE_H, 32'h0000_BEEF, 8,  32'hBEEF_AA44};
      rmw_tab[2] = '{32'h24, SIZE_B, 32'h0000_0077, 9,  32'h89AB_CD77};
      rmw_tab[3] = '{32'h28, SIZE_H, 32'h0000_1234, 10, 32'hFFFF_1234};
      rmw_tab[4] = '{32'h2F, SIZE_B, 32'h0000_005A, 11, 32'h5A00_0000};

      for (int k = 0; k < 64; k++) mem[k] = 32'h0;
      mem[0]  = 32'hFFFF_FFFF;
      mem[4]  = 32'hDEAD_BEEF;
      mem[8]  = 32'h1122_3344;
      mem[9]  = 32'h89AB_CDEF;
      mem[10] = 32'hFFFF_FFFF;
      mem[11] = 32'h0000_0000;
      mem[12] = 32'hCAFE_0012;
      last_d  = 32'h0;

      idle_inputs();
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      RST_N = 1'b1;

      // Reset state
      check("rst_i_rvalid", {31'd0, I_RVALID}, 32'd0);
      check("rst_d_rvalid", {31'd0, D_RVALID}, 32'd0);
      check("rst_d_err",    {31'd0, D_ERR},    32'd0);
      check("rst_i_rdata",  I_RDATA, 32'h0);
      check("rst_d_rdata",  D_RDATA, 32'h0);
      check("rst_ram_we",   {31'd0, RAM_WE}, 32'd0);

      // Single fetch, then low address bits ignored
      fetch(32'h10, 32'hDEAD_BEEF);
      fetch(32'h13, 32'hDEAD_BEEF);

      // Both requesting every cycle: I forced in on every fifth cycle
      i_win_pat = 10'b10_0001_0000;
      I_REQ = 1'b1; I_ADDR = 32'h10;
      D_REQ = 1'b1; D_WE = 1'b0; D_SIZE = SIZE_W; D_ADDR = 32'h30;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("starve_i_gnt", {31'd0, I_GNT}, {31'd0, i_win_pat[k]});
         check("starve_d_gnt", {31'd0, D_GNT}, {31'd0, ~i_win_pat[k]});
         if (i_win_pat[k]) i_q.push_back(32'hDEAD_BEEF);
         else begin
            d_q.push_back('{err: 1'b0, chk: 1'b1, data: 32'hCAFE_0012});
            last_d = 32'hCAFE_0012;
         end
         tick();
      end
      idle_inputs();
      tick();

      // Byte/half stores through read-modify-write
      for (int k = 0; k < 5; k++)
         rmw(rmw_tab[k].addr, rmw_tab[k].size, rmw_tab[k].wdata, rmw_tab[k].idx, rmw_tab[k].exp);

      // Misaligned accesses: error pulse, no write, D_RDATA held
      misalign(32'h23, SIZE_H, 1'b1);
      misalign(32'h22, SIZE_W, 1'b1);
      misalign(32'h20, 2'b11,  1'b1);
      misalign(32'h31, SIZE_H, 1'b0);
      check("mis_mem_unchanged", mem[8], 32'hBEEF_AA44);
      tick();

      // Reset while in the RMW write cycle
      D_REQ = 1'b1; D_WE = 1'b1; D_SIZE = SIZE_B; D_ADDR = 32'h2C; D_WDATA = 32'h11;
      #1;
      check("rstrmw_gnt", {31'd0, D_GNT}, 32'd1);
      tick();
      idle_inputs();
      RST_N = 1'b0;
      #1;
      check("rstrmw_we", {31'd0, RAM_WE}, 32'd0);
      tick();
      RST_N  = 1'b1;
      last_d = 32'h0;
      check("rstrmw_i_rvalid", {31'd0, I_RVALID}, 32'd0);
      check("rstrmw_d_rvalid", {31'd0, D_RVALID}, 32'd0);
      check("rstrmw_d_err",    {31'd0, D_ERR},    32'd0);
      check("rstrmw_mem",      mem[11], 32'h5A00_0000);
      misalign(32'h1, SIZE_W, 1'b0);
      load(32'h30, 32'hCAFE_0012);

      // Back-to-back word store then load of the same word
      D_REQ = 1'b1; D_WE = 1'b1; D_SIZE = SIZE_W; D_ADDR = 32'h0; D_WDATA = 32'h1;
      #1;
      check("sw_gnt",    {31'd0, D_GNT},  32'd1);
      check("sw_ram_we", {31'd0, RAM_WE}, 32'd1);
      check("sw_ram_wd", RAM_WD, 32'h1);
      check("sw_ram_a",  RAM_A,  32'h0);
      d_q.push_back('{err: 1'b0, chk: 1'b0, data: 32'h0});
      tick();
      check("sw_rvalid_lat", {31'd0, D_RVALID}, 32'd1);
      load(32'h0, 32'h0000_0001);
      misalign(32'h3, SIZE_W, 1'b0);

      repeat (3) tick();
      check("i_queue_drained", i_q.size(), 32'd0);
      check("d_queue_drained", d_q.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
